// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the LSU fault tracker slice.
//   el2_lsu_fault_pkt_t  precise fault packet carried D -> M -> R
//   EXC_ACCESS/MISALIGN  encodings of the exc_type field
//   el2_imp_state_e      state of the imprecise-error hold buffer
package el2_pkg;

    typedef struct packed {
        logic        valid;
        logic        store;
        logic        exc_type;
        logic [3:0]  mscause;
        logic [31:0] addr;
    } el2_lsu_fault_pkt_t;

    localparam logic EXC_ACCESS   = 1'b0;
    localparam logic EXC_MISALIGN = 1'b1;

    typedef enum logic {
        ImpIdle,
        ImpHeld
    } el2_imp_state_e;

endpackage

// File: rtl/el2_lsu_imprecise_buf.sv
// el2_lsu_imprecise_buf: single-entry hold buffer for imprecise bus errors.
// Ports:
//   clk, rst_l              clock, synchronous active-low reset
//   bus_err_valid/store/addr one-cycle bus error response and its attributes
//   imprecise_ack            TLU has consumed the held error
//   imprecise_load_any       held error is a load
//   imprecise_store_any      held error is a store
//   imprecise_addr_any       held error address (0 when nothing held)
//   imprecise_drop_cnt       saturating count of errors dropped while held
module el2_lsu_imprecise_buf
    import el2_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  bus_err_valid,
    input  logic                  bus_err_store,
    input  logic [31:0]           bus_err_addr,
    input  logic                  imprecise_ack,
    output logic                  imprecise_load_any,
    output logic                  imprecise_store_any,
    output logic [31:0]           imprecise_addr_any,
    output logic [DROP_CNT_W-1:0] imprecise_drop_cnt
);

    localparam logic [DROP_CNT_W-1:0] CntOne = 1;

    el2_imp_state_e        state_q, state_d;
    logic                  held_store_q;
    logic [31:0]           held_addr_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  latch_new;
    logic                  drop_err;
    logic                  held;

    // An ack in the same cycle frees the entry, so the new error takes it
    // instead of being dropped.
    assign latch_new = bus_err_valid & ((state_q == ImpIdle) | imprecise_ack);
    assign drop_err  = bus_err_valid & (state_q == ImpHeld) & ~imprecise_ack;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q      <= ImpIdle;
            held_store_q <= 1'b0;
            held_addr_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch_new) begin
                held_store_q <= bus_err_store;
                held_addr_q  <= bus_err_addr;
            end
            if (drop_err && !(&drop_cnt_q)) begin
                drop_cnt_q <= drop_cnt_q + CntOne;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ImpIdle: if (bus_err_valid) state_d = ImpHeld;
            ImpHeld: if (imprecise_ack && !bus_err_valid) state_d = ImpIdle;
            default: state_d = ImpIdle;
        endcase
    end

    // Outputs
    always_comb begin
        held                = (state_q == ImpHeld);
        imprecise_load_any  = held & ~held_store_q;
        imprecise_store_any = held & held_store_q;
        imprecise_addr_any  = held ? held_addr_q : 32'h0;
        imprecise_drop_cnt  = drop_cnt_q;
    end

endmodule

// File: rtl/el2_lsu_fault_tracker.sv
// el2_lsu_fault_tracker: carries D-stage LSU address-check faults through M and R
// and presents a precise error packet at R; optionally holds imprecise bus errors.
// Ports:
//   clk, rst_l                    clock, synchronous active-low reset
//   lsu_valid_d, lsu_store_d       LSU instruction in D and its type
//   access_fault_d, misaligned_fault_d, exc_mscause_d, start_addr_d  D-stage check results
//   flush_m_up, flush_r            pipeline kills
//   err_*_r                        precise exception packet at R
//   bus_err_*, imprecise_ack       imprecise error input and TLU handshake
//   imprecise_*                    held imprecise error and dropped-error count
module el2_lsu_fault_tracker
    import el2_pkg::*;
#(
    parameter int unsigned DROP_CNT_W   = 4,
    parameter bit          EN_IMPRECISE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  lsu_valid_d,
    input  logic                  lsu_store_d,
    input  logic                  access_fault_d,
    input  logic                  misaligned_fault_d,
    input  logic [3:0]            exc_mscause_d,
    input  logic [31:0]           start_addr_d,
    input  logic                  flush_m_up,
    input  logic                  flush_r,
    input  logic                  bus_err_valid,
    input  logic                  bus_err_store,
    input  logic [31:0]           bus_err_addr,
    input  logic                  imprecise_ack,
    output logic                  err_valid_r,
    output logic                  err_store_r,
    output logic                  err_exc_type_r,
    output logic [3:0]            err_mscause_r,
    output logic [31:0]           err_addr_r,
    output logic                  imprecise_load_any,
    output logic                  imprecise_store_any,
    output logic [31:0]           imprecise_addr_any,
    output logic [DROP_CNT_W-1:0] imprecise_drop_cnt
);

    logic               fault_d;
    el2_lsu_fault_pkt_t pkt_m_q;
    el2_lsu_fault_pkt_t pkt_r_q;

    assign fault_d = lsu_valid_d & (access_fault_d | misaligned_fault_d);

    // M stage: payload only moves on a fault so a stale packet stays put otherwise.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pkt_m_q <= '0;
        end else begin
            pkt_m_q.valid <= fault_d & ~flush_m_up;
            if (fault_d) begin
                pkt_m_q.store    <= lsu_store_d;
                pkt_m_q.exc_type <= misaligned_fault_d ? EXC_MISALIGN : EXC_ACCESS;
                pkt_m_q.mscause  <= exc_mscause_d;
                pkt_m_q.addr     <= start_addr_d;
            end
        end
    end

    // R stage: flush_m_up also kills the instruction leaving M.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pkt_r_q <= '0;
        end else begin
            pkt_r_q       <= pkt_m_q;
            pkt_r_q.valid <= pkt_m_q.valid & ~flush_m_up;
        end
    end

    always_comb begin
        err_valid_r    = pkt_r_q.valid & ~flush_r;
        err_store_r    = pkt_r_q.store;
        err_exc_type_r = pkt_r_q.exc_type;
        err_mscause_r  = pkt_r_q.mscause;
        err_addr_r     = pkt_r_q.addr;
    end

    if (EN_IMPRECISE) begin : g_imprecise
        el2_lsu_imprecise_buf #(
            .DROP_CNT_W(DROP_CNT_W)
        ) u_imprecise_buf (
            .clk                (clk),
            .rst_l              (rst_l),
            .bus_err_valid      (bus_err_valid),
            .bus_err_store      (bus_err_store),
            .bus_err_addr       (bus_err_addr),
            .imprecise_ack      (imprecise_ack),
            .imprecise_load_any (imprecise_load_any),
            .imprecise_store_any(imprecise_store_any),
            .imprecise_addr_any (imprecise_addr_any),
            .imprecise_drop_cnt (imprecise_drop_cnt)
        );
    end else begin : g_no_imprecise
        assign imprecise_load_any  = 1'b0;
        assign imprecise_store_any = 1'b0;
        assign imprecise_addr_any  = 32'h0;
        assign imprecise_drop_cnt  = '0;
    end

endmodule

// File: tb/tb_el2_lsu_fault_tracker.sv
// Testbench for el2_lsu_fault_tracker: directed stimulus pushes expected,
// cycle-tagged responses into queues; a negedge monitor pops and compares.
module tb_el2_lsu_fault_tracker;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        lsu_valid_d = 1'b0, lsu_store_d = 1'b0;
    logic        access_fault_d = 1'b0, misaligned_fault_d = 1'b0;
    logic [3:0]  exc_mscause_d = '0;
    logic [31:0] start_addr_d = '0;
    logic        flush_m_up = 1'b0, flush_r = 1'b0;
    logic        bus_err_valid = 1'b0, bus_err_store = 1'b0;
    logic [31:0] bus_err_addr = '0;
    logic        imprecise_ack = 1'b0;
    logic        err_valid_r, err_store_r, err_exc_type_r;
    logic [3:0]  err_mscause_r;
    logic [31:0] err_addr_r;
    logic        imprecise_load_any, imprecise_store_any;
    logic [31:0] imprecise_addr_any;
    logic [3:0]  imprecise_drop_cnt;

    el2_lsu_fault_tracker #(
        .DROP_CNT_W  (4),
        .EN_IMPRECISE(1'b1)
    ) dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .lsu_valid_d        (lsu_valid_d),
        .lsu_store_d        (lsu_store_d),
        .access_fault_d     (access_fault_d),
        .misaligned_fault_d (misaligned_fault_d),
        .exc_mscause_d      (exc_mscause_d),
        .start_addr_d       (start_addr_d),
        .flush_m_up         (flush_m_up),
        .flush_r            (flush_r),
        .bus_err_valid      (bus_err_valid),
        .bus_err_store      (bus_err_store),
        .bus_err_addr       (bus_err_addr),
        .imprecise_ack      (imprecise_ack),
        .err_valid_r        (err_valid_r),
        .err_store_r        (err_store_r),
        .err_exc_type_r     (err_exc_type_r),
        .err_mscause_r      (err_mscause_r),
        .err_addr_r         (err_addr_r),
        .imprecise_load_any (imprecise_load_any),
        .imprecise_store_any(imprecise_store_any),
        .imprecise_addr_any (imprecise_addr_any),
        .imprecise_drop_cnt (imprecise_drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        valid;
        logic        chk_pay;
        logic        store;
        logic        exc;
        logic [3:0]  ms;
        logic [31:0] addr;
    } pexp_t;

    typedef struct {
        int          cyc;
        logic        load;
        logic        store;
        logic [31:0] addr;
        logic [3:0]  cnt;
    } iexp_t;

    pexp_t pq[$];
    iexp_t iq[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_p(input int tag, input logic v, input logic cp, input logic st,
                         input logic ex, input logic [3:0] ms, input logic [31:0] a);
        pexp_t e;
        e.cyc = tag; e.valid = v; e.chk_pay = cp; e.store = st; e.exc = ex;
        e.ms = ms; e.addr = a;
        pq.push_back(e);
    endtask

    task automatic exp_i(input int tag, input logic ld, input logic st,
                         input logic [31:0] a, input logic [3:0] cnt);
        iexp_t e;
        e.cyc = tag; e.load = ld; e.store = st; e.addr = a; e.cnt = cnt;
        iq.push_back(e);
    endtask

    // Monitor: compare tagged expectations; untagged cycles must show no precise error.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            while (pq.size() != 0 && pq[0].cyc < cyc) begin
                pexp_t m;
                m = pq.pop_front();
                chk("p_missed_tag", 32'(m.cyc), 32'(cyc));
            end
            if (pq.size() != 0 && pq[0].cyc == cyc) begin
                pexp_t e;
                e = pq.pop_front();
                chk("err_valid_r", 32'(err_valid_r), 32'(e.valid));
                if (e.chk_pay) begin
                    chk("err_store_r", 32'(err_store_r), 32'(e.store));
                    chk("err_exc_type_r", 32'(err_exc_type_r), 32'(e.exc));
                    chk("err_mscause_r", 32'(err_mscause_r), 32'(e.ms));
                    chk("err_addr_r", err_addr_r, e.addr);
                end
            end else if (err_valid_r !== 1'b0) begin
                chk("err_valid_r_unexpected", 32'(err_valid_r), 32'h0);
            end
            while (iq.size() != 0 && iq[0].cyc < cyc) begin
                iexp_t m;
                m = iq.pop_front();
                chk("i_missed_tag", 32'(m.cyc), 32'(cyc));
            end
            if (iq.size() != 0 && iq[0].cyc == cyc) begin
                iexp_t e;
                e = iq.pop_front();
                chk("imprecise_load_any", 32'(imprecise_load_any), 32'(e.load));
                chk("imprecise_store_any", 32'(imprecise_store_any), 32'(e.store));
                chk("imprecise_addr_any", imprecise_addr_any, e.addr);
                chk("imprecise_drop_cnt", 32'(imprecise_drop_cnt), 32'(e.cnt));
            end
        end
    end

    // Advance to just after the next edge and return every pulse input to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        lsu_valid_d = 1'b0; lsu_store_d = 1'b0;
        access_fault_d = 1'b0; misaligned_fault_d = 1'b0;
        exc_mscause_d = '0; start_addr_d = '0;
        flush_m_up = 1'b0; flush_r = 1'b0;
        bus_err_valid = 1'b0; bus_err_store = 1'b0; bus_err_addr = '0;
        imprecise_ack = 1'b0;
    endtask

    task automatic lsu(input logic st, input logic acc, input logic mis,
                       input logic [3:0] ms, input logic [31:0] a);
        lsu_valid_d = 1'b1; lsu_store_d = st;
        access_fault_d = acc; misaligned_fault_d = mis;
        exc_mscause_d = ms; start_addr_d = a;
    endtask

    task automatic bus_err(input logic st, input logic [31:0] a);
        bus_err_valid = 1'b1; bus_err_store = st; bus_err_addr = a;
    endtask

    initial begin
        logic [3:0] cnt;

        // Reset held across two edges; everything reads 0.
        tick();
        exp_p(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        exp_i(cyc + 1, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        rst_l = 1'b1;

        // Load access fault.
        tick();
        lsu(1'b0, 1'b1, 1'b0, 4'h2, 32'hF004_0000);
        exp_p(cyc + 2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 32'hF004_0000);
        // Store with both faults: misaligned wins.
        tick();
        lsu(1'b1, 1'b1, 1'b1, 4'h2, 32'h1000_0003);
        exp_p(cyc + 2, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 32'h1000_0003);
        // Faults that are not valid LSU ops, and valid ops with no fault.
        tick();
        access_fault_d = 1'b1; misaligned_fault_d = 1'b1; start_addr_d = 32'hDEAD_0000;
        tick();
        lsu(1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_1234);
        access_fault_d = 1'b0;

        // flush_m_up kills a fault in M; payload still advances to R.
        tick();
        lsu(1'b0, 1'b1, 1'b0, 4'h5, 32'h0000_000A);
        exp_p(cyc + 2, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 32'h0000_000A);
        tick();
        flush_m_up = 1'b1;
        tick();
        tick();

        // flush_r kills at R combinationally while the payload stays visible.
        tick();
        lsu(1'b1, 1'b0, 1'b1, 4'h1, 32'h0000_000B);
        exp_p(cyc + 2, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 32'h0000_000B);
        tick();
        tick();
        flush_r = 1'b1;
        tick();

        // Back-to-back faults with distinct addresses.
        tick();
        lsu(1'b0, 1'b1, 1'b0, 4'h3, 32'h0000_0100);
        exp_p(cyc + 2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_0100);
        tick();
        lsu(1'b0, 1'b0, 1'b1, 4'h7, 32'h0000_0204);
        exp_p(cyc + 2, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 32'h0000_0204);
        tick();
        tick();
        tick();

        // Imprecise: first store error is held.
        tick();
        bus_err(1'b1, 32'h2000_0010);
        exp_i(cyc + 1, 1'b0, 1'b1, 32'h2000_0010, 4'h0);
        // 17 more without ack: counter saturates at 15, original entry kept.
        for (int i = 0; i < 17; i++) begin
            tick();
            bus_err(1'b0, 32'h1111_0000 + 32'(i));
            cnt = (i >= 14) ? 4'hF : 4'(i + 1);
            exp_i(cyc + 1, 1'b0, 1'b1, 32'h2000_0010, cnt);
        end
        // Ack releases the entry; the drop count is sticky.
        tick();
        imprecise_ack = 1'b1;
        exp_i(cyc + 1, 1'b0, 1'b0, 32'h0, 4'hF);
        // Ack while idle does nothing.
        tick();
        imprecise_ack = 1'b1;
        exp_i(cyc + 1, 1'b0, 1'b0, 32'h0, 4'hF);
        tick();
        bus_err(1'b1, 32'h4000_0000);
        exp_i(cyc + 1, 1'b0, 1'b1, 32'h4000_0000, 4'hF);
        // Ack plus new error in one cycle: replaced, no drop.
        tick();
        imprecise_ack = 1'b1;
        bus_err(1'b0, 32'h3000_0000);
        exp_i(cyc + 1, 1'b1, 1'b0, 32'h3000_0000, 4'hF);
        tick();
        exp_i(cyc + 1, 1'b1, 1'b0, 32'h3000_0000, 4'hF);

        // Reset while HELD clears everything, including the R payload.
        tick();
        rst_l = 1'b0;
        exp_i(cyc + 1, 1'b0, 1'b0, 32'h0, 4'h0);
        exp_p(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        rst_l = 1'b1;
        exp_i(cyc + 1, 1'b0, 1'b0, 32'h0, 4'h0);

        for (int i = 0; i < 4; i++) tick();
        chk("precise_queue_drained", 32'(pq.size()), 32'h0);
        chk("imprecise_queue_drained", 32'(iq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
